b11_stim_driver: RTL and testbench

- Transmit-side driver for the b11 scrambler's strobe/data input protocol (stbi, x_in).
- Accepts 6-bit words from an upstream valid/ready source and presents each to b11 as a single-cycle low strobe.
- Waits a fixed settle window, then samples b11's x_out and returns it downstream with the sent word and a skip flag.
- Used as the producer end of the b11 interface in block-level and concolic test harnesses.

---
 rtl/b11_stim_driver.sv | 129 ++++++++++++
 tb/tb_b11_stim_driver.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/b11_stim_driver.sv
// Producer side of the b11 stbi/x_in protocol: strobes one word, waits for the
// scrambler to settle, then hands x_out back downstream with the word and a skip flag.
module b11_stim_driver #(
    parameter int DW             = 6,
    parameter int STARTUP_CYCLES = 2,
    parameter int WAIT_CYCLES    = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          stbi,
    output logic [DW-1:0] x_in,
    input  logic [DW-1:0] dut_x_out,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic [DW-1:0] res_word,
    output logic          res_skip,
    output logic [7:0]    tx_count
);

    typedef enum logic [2:0] {
        S_STARTUP,
        S_IDLE,
        S_STROBE,
        S_WAIT,
        S_REPORT
    } state_t;

    localparam logic [7:0]    ST_LAST   = 8'(STARTUP_CYCLES - 1);
    localparam logic [7:0]    WT_LAST   = 8'(WAIT_CYCLES - 1);
    localparam logic [DW-1:0] SKIP_LO   = DW'(27);
    localparam logic [DW-1:0] WORD_ONES = {DW{1'b1}};

    state_t        state, state_nxt;
    logic [7:0]    cnt, cnt_nxt;
    logic [DW-1:0] word, word_nxt;
    logic          ld_res, clr_res, tx_inc;
    logic          skip_nxt;

    // 0 and 63 are handled by b11; every other word above 26 is dropped by it
    assign skip_nxt = (word != '0) && (word != WORD_ONES) && (word >= SKIP_LO);

    // stbi is decoded from registered state, so it is glitch-free and one cycle wide
    assign in_ready = (state == S_IDLE);
    assign stbi     = (state != S_STROBE);
    assign x_in     = word;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        word_nxt  = word;
        ld_res    = 1'b0;
        clr_res   = 1'b0;
        tx_inc    = 1'b0;
        case (state)
            S_STARTUP: begin
                if (cnt == ST_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            S_IDLE: begin
                if (in_valid) begin
                    word_nxt  = in_data;
                    state_nxt = S_STROBE;
                end
            end
            S_STROBE: begin
                tx_inc    = 1'b1;
                cnt_nxt   = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == WT_LAST) begin
                    ld_res    = 1'b1;
                    state_nxt = S_REPORT;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    clr_res   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_STARTUP;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_STARTUP;
            cnt   <= '0;
            word  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            word  <= word_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_word  <= '0;
            res_skip  <= 1'b0;
            tx_count  <= '0;
        end else begin
            if (ld_res) begin
                res_valid <= 1'b1;
                res_data  <= dut_x_out;
                res_word  <= word;
                res_skip  <= skip_nxt;
            end else if (clr_res) begin
                res_valid <= 1'b0;
            end
            if (tx_inc)
                tx_count <= tx_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_b11_stim_driver.sv
// Directed bench for b11_stim_driver; the bench plays b11 by driving dut_x_out
// with hand-computed scrambler outputs.
module tb_b11_stim_driver;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [5:0] in_data = '0;
    logic       in_ready;
    logic       stbi;
    logic [5:0] x_in;
    logic [5:0] dut_x_out = '0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [5:0] res_data;
    logic [5:0] res_word;
    logic       res_skip;
    logic [7:0] tx_count;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] exp_tx = '0;

    b11_stim_driver dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .stbi(stbi), .x_in(x_in), .dut_x_out(dut_x_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_word(res_word), .res_skip(res_skip), .tx_count(tx_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full transaction: handshake, strobe, settle, result, optional backpressure, accept
    task automatic send(input logic [5:0] w, input logic [5:0] xo, input logic skip, input int hold);
        int  t;
        int  lat;
        int  lows;
        bit  done;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        chk("ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        in_data  = 6'($urandom);
        chk("strobe_low", stbi, 0);
        chk("strobe_x_in", x_in, w);
        chk("strobe_in_ready", in_ready, 0);
        exp_tx    = exp_tx + 8'd1;
        dut_x_out = xo ^ 6'h2a;
        lat  = 0;
        lows = 0;
        done = 0;
        for (int c = 1; c <= 40 && !done; c++) begin
            tick();
            if (!stbi) lows++;
            if (c == 1) chk("tx_count", tx_count, exp_tx);
            if (c == 12) dut_x_out = xo;
            if (res_valid) begin
                done = 1;
                lat  = c;
            end
        end
        chk("latency", lat, 17);
        chk("single_strobe", lows, 0);
        dut_x_out = xo ^ 6'h15;
        chk("res_data", res_data, xo);
        chk("res_word", res_word, w);
        chk("res_skip", res_skip, skip);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, xo);
            chk("hold_ready", in_ready, 0);
            chk("hold_stbi", stbi, 1);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("accept_valid", res_valid, 0);
        chk("accept_idle", in_ready, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_stbi"}, stbi, 1);
        chk({tag, "_x_in"}, x_in, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_word"}, res_word, 0);
        chk({tag, "_res_skip"}, res_skip, 0);
        chk({tag, "_tx_count"}, tx_count, 0);
    endtask

    initial begin
        repeat (3) tick();
        chk_reset_outputs("rst");
        reset = 1'b1;
        tick();
        chk("startup1_ready", in_ready, 0);
        tick();
        chk("startup2_ready", in_ready, 1);

        send(6'd0,  6'd0,  1'b0, 0);
        send(6'd63, 6'd63, 1'b0, 0);
        send(6'd5,  6'd37, 1'b0, 0);
        send(6'd40, 6'd37, 1'b1, 10);
        send(6'd26, 6'd11, 1'b0, 0);
        send(6'd27, 6'd11, 1'b1, 0);
        send(6'd62, 6'd11, 1'b1, 0);
        send(6'd1,  6'd50, 1'b0, 0);

        // reset lands in the middle of WAIT
        in_valid = 1'b1;
        in_data  = 6'd9;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        #1;
        chk_reset_outputs("midwait");
        exp_tx = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("restart1_ready", in_ready, 0);
        tick();
        chk("restart2_ready", in_ready, 1);
        begin
            int pulses;
            pulses = 0;
            for (int c = 0; c < 25; c++) begin
                tick();
                if (res_valid) pulses++;
            end
            chk("no_stale_result", pulses, 0);
        end

        for (int i = 0; i < 256; i++) begin
            logic [5:0] w;
            w = 6'(i);
            send(w, 6'(i * 7), (w != 0) && (w != 63) && (w > 26), 0);
        end
        chk("tx_wrap", tx_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
